// File: rtl/pattern_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pattern_detect_ctrl: programmable serial pattern detector with run ctrl  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pattern_detect_ctrl #(
   parameter int PW = 8,
   parameter int CW = 8,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [PW-1:0] cfg_pattern,
   input  logic [LW-1:0] cfg_len,
   input  logic          cfg_overlap,
   input  logic [CW-1:0] cfg_target,
   output logic          cfg_err,
   input  logic          start,
   input  logic          abort,
   input  logic          in,
   input  logic          in_valid,
   output logic          detect,
   output logic [CW-1:0] match_count,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [LW-1:0] c_pw       = LW'(PW);
   localparam logic [CW-1:0] c_cnt_max  = {CW{1'b1}};

   state_t        r_state;
   state_t        w_state_next;

   logic [PW-1:0] r_pattern;
   logic [LW-1:0] r_len;
   logic          r_overlap;
   logic [CW-1:0] r_target;
   logic          r_loaded;

   // Only PW-1 history bits are stored: the oldest bit of the post-shift
   // window is always the incoming shift-out of the stored history.
   logic [PW-2:0] r_hist;
   logic [LW-1:0] r_fill;
   logic [CW-1:0] r_count;
   logic          r_detect;
   logic          r_cfg_err;

   logic          w_idle;
   logic          w_cfg_hs;
   logic          w_len_ok;
   logic          w_cfg_accept;
   logic          w_cfg_reject;
   logic          w_start_go;
   logic [PW-1:0] w_shift_next;
   logic [LW-1:0] w_fill_inc;
   logic [PW-1:0] w_mask;
   logic          w_hit;
   logic          w_run_step;
   logic          w_match;
   logic [CW-1:0] w_count_inc;
   logic          w_target_hit;

   assign w_idle       = (r_state == S_IDLE);
   assign w_cfg_hs     = cfg_valid && w_idle;
   assign w_len_ok     = (cfg_len != '0) && (cfg_len <= c_pw);
   assign w_cfg_accept = w_cfg_hs && w_len_ok;
   assign w_cfg_reject = w_cfg_hs && !w_len_ok;
   // A config accepted on the start edge is already good enough to run on.
   assign w_start_go   = w_idle && start && (r_loaded || w_cfg_accept);

   assign w_shift_next = {r_hist, in};
   assign w_fill_inc   = (r_fill >= c_pw) ? r_fill : r_fill + LW'(1);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < PW; i++) begin
         w_mask[i] = (i < int'(r_len));
      end
   end

   assign w_hit        = (w_fill_inc >= r_len) &&
                         ((w_shift_next & w_mask) == (r_pattern & w_mask));
   // Abort wins over any same-edge bit, so it suppresses the whole step.
   assign w_run_step   = (r_state == S_RUN) && !abort && in_valid;
   assign w_match      = w_run_step && w_hit;
   assign w_count_inc  = (r_count == c_cnt_max) ? r_count : r_count + CW'(1);
   assign w_target_hit = w_match && (r_target != '0) && (w_count_inc == r_target);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      cfg_ready    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            cfg_ready = 1'b1;
            if (w_start_go) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (abort) begin
               w_state_next = S_IDLE;
            end else if (w_target_hit) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pattern <= '0;
         r_len     <= '0;
         r_overlap <= 1'b0;
         r_target  <= '0;
         r_loaded  <= 1'b0;
         r_hist    <= '0;
         r_fill    <= '0;
         r_count   <= '0;
         r_detect  <= 1'b0;
         r_cfg_err <= 1'b0;
      end else begin
         r_detect  <= w_match;
         r_cfg_err <= w_cfg_reject;

         if (w_cfg_accept) begin
            r_pattern <= cfg_pattern;
            r_len     <= cfg_len;
            r_overlap <= cfg_overlap;
            r_target  <= cfg_target;
            r_loaded  <= 1'b1;
         end

         if (w_start_go) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
         end else if (w_run_step) begin
            r_hist <= w_shift_next[PW-2:0];
            // Without overlap the matched bits must not seed the next match.
            r_fill <= (w_hit && !r_overlap) ? '0 : w_fill_inc;
            if (w_hit) begin
               r_count <= w_count_inc;
            end
         end
      end
   end

   assign detect      = r_detect;
   assign cfg_err     = r_cfg_err;
   assign match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_pattern_detect_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pattern_detect_ctrl: scenario and randomized bench with bit-history   |
// | reference model. Revision: 1.0                                           |
// +--------------------------------------------------------------------------+
module tb_pattern_detect_ctrl;

   localparam int PW = 8;
   localparam int CW = 8;
   localparam int LW = 4;

   logic          clk;
   logic          rst_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [PW-1:0] cfg_pattern;
   logic [LW-1:0] cfg_len;
   logic          cfg_overlap;
   logic [CW-1:0] cfg_target;
   logic          cfg_err;
   logic          start;
   logic          abort;
   logic          in_b;
   logic          in_valid;
   logic          detect;
   logic [CW-1:0] match_count;
   logic          busy;
   logic          done;

   int checks = 0;
   int errors = 0;

   pattern_detect_ctrl #(.PW(PW), .CW(CW), .LW(LW)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
      .cfg_err(cfg_err), .start(start), .abort(abort),
      .in(in_b), .in_valid(in_valid), .detect(detect),
      .match_count(match_count), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {cfg_ready, busy, done, detect, cfg_err, match_count}
   wire [CW+4:0] act = {cfg_ready, busy, done, detect, cfg_err, match_count};

   // Reference model: keeps the list of valid bits seen since the last
   // clear and compares its newest len entries against the pattern.
   bit m_loaded, m_ovl, m_running, m_donep, m_det, m_err;
   int m_pat, m_len, m_tgt, m_count;
   int hist[$];

   task automatic model_reset();
      m_loaded = 0; m_ovl = 0; m_running = 0; m_donep = 0; m_det = 0; m_err = 0;
      m_pat = 0; m_len = 0; m_tgt = 0; m_count = 0;
      hist.delete();
   endtask

   task automatic model_edge();
      bit det;
      bit err;
      int v;
      det = 0; err = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (m_donep) begin
         m_donep = 0;
      end else if (!m_running) begin
         if (cfg_valid) begin
            if (int'(cfg_len) >= 1 && int'(cfg_len) <= PW) begin
               m_pat = int'(cfg_pattern); m_len = int'(cfg_len);
               m_ovl = cfg_overlap; m_tgt = int'(cfg_target); m_loaded = 1;
            end else begin
               err = 1;
            end
         end
         if (start && m_loaded) begin
            m_running = 1; m_count = 0; hist.delete();
         end
      end else if (abort) begin
         m_running = 0;
      end else if (in_valid) begin
         hist.push_back(int'(in_b));
         if (hist.size() >= m_len) begin
            v = 0;
            for (int k = 0; k < m_len; k++) v |= hist[hist.size()-1-k] << k;
            if (v == (m_pat & ((1 << m_len) - 1))) begin
               det = 1;
               if (m_count < (1 << CW) - 1) m_count++;
               if (!m_ovl) hist.delete();
               if (m_tgt != 0 && m_count == m_tgt) begin
                  m_running = 0; m_donep = 1;
               end
            end
         end
         if (hist.size() > 32) void'(hist.pop_front());
      end
      m_det = det; m_err = err;
   endtask

   function automatic logic [CW+4:0] exp_vec();
      return {~(m_running | m_donep), m_running, m_donep, m_det, m_err, CW'(m_count)};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      cfg_valid = 0; start = 0; abort = 0; in_valid = 0; in_b = 0;
   endtask

   task automatic setup(input int pat, input int len, input bit ovl, input int tgt);
      cfg_pattern = PW'(pat); cfg_len = LW'(len); cfg_overlap = ovl;
      cfg_target = CW'(tgt); cfg_valid = 1;
      tick();
      cfg_valid = 0; start = 1;
      tick();
      start = 0;
   endtask

   task automatic apply_reset();
      rst_n = 0;
      tick(); tick();
      rst_n = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      cfg_pattern = '0; cfg_len = '0; cfg_overlap = 0; cfg_target = '0;
      model_reset();
      apply_reset();
      checks++;
      if (act !== {1'b1, 4'b0000, {CW{1'b0}}}) begin
         errors++; $display("FAIL reset_state got=%h want=%h", act, {1'b1, 4'b0000, {CW{1'b0}}});
      end
   endtask

   task automatic test_overlap();
      logic [4:0] dmask;
      setup(3'b111, 3, 1, 0);
      checks++;
      if (act !== exp_vec()) begin errors++; $display("FAIL overlap_start got=%h want=%h", act, exp_vec()); end
      for (int i = 0; i < 5; i++) begin
         in_b = 1; in_valid = 1;
         tick();
         dmask[i] = detect;
         checks++;
         if (act !== exp_vec()) begin errors++; $display("FAIL overlap_bit%0d got=%h want=%h", i, act, exp_vec()); end
      end
      idle_inputs();
      checks++;
      if ({dmask, match_count, busy} !== {5'b11100, CW'(3), 1'b1}) begin
         errors++; $display("FAIL overlap_summary got=%b/%0d/%b want=11100/3/1", dmask, match_count, busy);
      end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_nonoverlap();
      logic [5:0] dmask;
      setup(3'b111, 3, 0, 0);
      for (int i = 0; i < 6; i++) begin
         in_b = 1; in_valid = 1;
         tick();
         dmask[i] = detect;
         checks++;
         if (act !== exp_vec()) begin errors++; $display("FAIL nonoverlap_bit%0d got=%h want=%h", i, act, exp_vec()); end
      end
      idle_inputs();
      checks++;
      if ({dmask, match_count} !== {6'b100100, CW'(2)}) begin
         errors++; $display("FAIL nonoverlap_summary got=%b/%0d want=100100/2", dmask, match_count);
      end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_target();
      logic [4:0] dmask;
      logic [4:0] bits;
      bits = 5'b10101;
      setup(3'b101, 3, 1, 2);
      for (int i = 0; i < 5; i++) begin
         in_b = bits[i]; in_valid = 1;
         tick();
         dmask[i] = detect;
         checks++;
         if (act !== exp_vec()) begin errors++; $display("FAIL target_bit%0d got=%h want=%h", i, act, exp_vec()); end
      end
      checks++;
      if ({dmask, done, busy, detect, match_count} !== {5'b10100, 3'b101, CW'(2)}) begin
         errors++; $display("FAIL target_done got=%b %b%b%b/%0d want=10100 101/2", dmask, done, busy, detect, match_count);
      end
      in_b = 1; in_valid = 1;
      tick();
      idle_inputs();
      checks++;
      if ({cfg_ready, busy, done, detect, match_count} !== {4'b1000, CW'(2)}) begin
         errors++; $display("FAIL target_idle got=%b%b%b%b/%0d want=1000/2", cfg_ready, busy, done, detect, match_count);
      end
   endtask

   task automatic test_gaps();
      logic [5:0] vld;
      logic [5:0] dmask;
      vld = 6'b101001;
      setup(3'b111, 3, 1, 0);
      for (int i = 0; i < 6; i++) begin
         in_valid = vld[i];
         in_b = vld[i] ? 1'b1 : 1'($urandom_range(0, 1));
         tick();
         dmask[i] = detect;
         checks++;
         if (act !== exp_vec()) begin errors++; $display("FAIL gaps_cyc%0d got=%h want=%h", i, act, exp_vec()); end
      end
      idle_inputs();
      checks++;
      if (dmask !== 6'b100000) begin errors++; $display("FAIL gaps_detects got=%b want=100000", dmask); end
      abort = 1; tick(); abort = 0;
   endtask

   task automatic test_illegal_cfg();
      apply_reset();
      for (int n = 0; n < 2; n++) begin
         cfg_pattern = PW'(3'b111); cfg_len = (n == 0) ? LW'(0) : LW'(9);
         cfg_valid = 1;
         tick();
         cfg_valid = 0;
         checks++;
         if (cfg_err !== 1'b1 || act !== exp_vec()) begin
            errors++; $display("FAIL illegal_len%0d_err got=%h want=%h", int'(cfg_len), act, exp_vec());
         end
         tick();
         checks++;
         if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_err_pulse got=%b want=0", cfg_err); end
         start = 1;
         tick();
         start = 0;
         checks++;
         if (busy !== 1'b0 || act !== exp_vec()) begin
            errors++; $display("FAIL illegal_start busy got=%b want=0", busy);
         end
      end
   endtask

   task automatic test_abort_reset();
      setup(3'b111, 3, 1, 5);
      for (int i = 0; i < 3; i++) begin
         in_b = 1; in_valid = 1;
         tick();
         checks++;
         if (act !== exp_vec()) begin errors++; $display("FAIL abort_bit%0d got=%h want=%h", i, act, exp_vec()); end
      end
      in_valid = 1; abort = 1;
      tick();
      idle_inputs();
      checks++;
      if ({cfg_ready, busy, done, match_count} !== {3'b100, CW'(1)}) begin
         errors++; $display("FAIL abort_idle got=%b%b%b/%0d want=100/1", cfg_ready, busy, done, match_count);
      end
      start = 1; tick(); start = 0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL restart busy got=%b want=1", busy); end
      for (int i = 0; i < 3; i++) begin
         in_b = 1; in_valid = 1; tick();
      end
      rst_n = 0;
      #1;
      model_reset();
      checks++;
      if (act !== {1'b1, 4'b0000, {CW{1'b0}}}) begin
         errors++; $display("FAIL midrun_reset got=%h want=%h", act, {1'b1, 4'b0000, {CW{1'b0}}});
      end
      idle_inputs();
      tick(); tick();
      rst_n = 1;
      start = 1; tick(); start = 0;
      checks++;
      if (busy !== 1'b0 || act !== exp_vec()) begin
         errors++; $display("FAIL reset_cfg_cleared busy got=%b want=0", busy);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         cfg_valid   = ($urandom_range(0, 7) == 0);
         cfg_len     = LW'($urandom_range(0, 10));
         cfg_pattern = PW'($urandom);
         cfg_overlap = 1'($urandom_range(0, 1));
         cfg_target  = CW'($urandom_range(0, 3));
         start       = ($urandom_range(0, 5) == 0);
         abort       = ($urandom_range(0, 39) == 0);
         in_valid    = ($urandom_range(0, 3) != 0);
         in_b        = 1'($urandom_range(0, 1));
         tick();
         checks++;
         if (act !== exp_vec()) begin errors++; $display("FAIL random_cyc%0d got=%h want=%h", c, act, exp_vec()); end
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 0;
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_target();
      test_gaps();
      test_illegal_cfg();
      test_abort_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pattern_detect_ctrl.md
# pattern_detect_ctrl

Run-time programmable serial pattern-detection controller. It generalises the team's fixed "111" detector. A host loads a pattern of up to PW bits, its length, an overlap mode and a target match count, then starts a run. The block shifts in qualified serial bits, pulses `detect` on every match, counts matches and retires the run with a `done` pulse when the target is reached. It sits between a host/config interface and a serial bit stream. It is the sequencing and configuration owner for pattern detection in the design.

## Interface
- `PW`, 8, maximum pattern width in bits (2..15)
- `CW`, 8, match counter width
- `LW`, 4, width of `cfg_len` (must hold PW)
- `clk`  in  1  single clock, all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cfg_valid`  in  1  config offer
- `cfg_ready`  out  1  high only in IDLE
- `cfg_pattern`  in  PW  pattern; bit [len-1] is the oldest bit, bit 0 the newest
- `cfg_len`  in  LW  pattern length, legal 1..PW
- `cfg_overlap`  in  1  1 = overlapping matches allowed
- `cfg_target`  in  CW  matches that end the run; 0 = run until abort
- `cfg_err`  out  1  one-cycle pulse: offered config rejected
- `start`  in  1  begin run (IDLE only)
- `abort`  in  1  end run without `done`
- `in`  in  1  serial data bit
- `in_valid`  in  1  qualifies `in`
- `detect`  out  1  one-cycle match pulse
- `match_count`  out  CW  matches in current/last run
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse, target reached

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: `cfg_ready`=1 and all other outputs 0. The config registers clear, and `cfg_loaded`=0.
- IDLE, config handshake:
  - A handshake is `cfg_valid` && `cfg_ready`.
  - If `cfg_len` is in 1..PW, the pattern, length, overlap and target are latched and `cfg_loaded` is set.
  - Otherwise the offer is dropped, the previous config is kept, and `cfg_err` pulses for one cycle.
- IDLE, start:
  - `start` with `cfg_loaded`=1 moves to RUN.
  - The same edge clears `match_count`, the shift register and the fill counter.
  - `start` with `cfg_loaded`=0 is ignored.
  - `start` in the same cycle as an accepted handshake is honoured. The run uses the newly latched config.
- RUN:
  - `cfg_ready`=0; `cfg_valid` is ignored (no `cfg_err`); `start` is ignored.
  - On each `in_valid` edge, the shift register shifts left with `in` entering bit 0. The fill counter increments, saturating at PW.
  - Match condition: fill ≥ len and shift[len-1:0] == pattern[len-1:0], evaluated on the post-shift value.
- On a match:
  - `detect`=1 for the following cycle, and `match_count` increments on the same edge. The counter saturates at 2^CW−1.
  - If `cfg_overlap`=0, fill is cleared so that history bits cannot be reused.
  - If target≠0 and the incremented count equals target, the next state is DONE.
- `in_valid`=0 cycles: no shift, no match, no state change.
- `abort` in RUN moves to IDLE. There is no `done`, `match_count` holds, and `abort` has priority over a same-edge match-to-DONE. `abort` outside RUN is ignored.
- DONE lasts exactly one cycle: `done`=1 and `busy`=0, then it returns to IDLE. `in_valid` bits arriving during DONE are discarded.
- `match_count` holds its value in IDLE until the next accepted `start`.
- Asserting `rst_n` low mid-run forces IDLE and clears everything immediately, including the loaded config.

## Timing
- `detect` latency: the edge that samples the completing bit raises `detect` for exactly one cycle after it.
- `match_count` is updated on that same edge.
- `done` is coincident with the final `detect`, and `busy` falls in that same cycle.
- `busy` rises on the edge after `start` is sampled.
- The earliest first detect is len `in_valid` edges after entering RUN.
- `cfg_err` is asserted in the cycle after the rejected offer.
- `cfg_ready` returns high in the cycle after DONE, or immediately after `abort`.

## Test plan
- **Overlapping, unlimited run:** pattern=111, len=3, overlap=1, target=0; in=1,1,1,1,1 with `in_valid` every cycle. Required: `detect` after bits 3, 4 and 5; `match_count`=3; `busy` stays 1.
- **Non-overlapping:** same pattern with overlap=0; in=1,1,1,1,1,1. Required: `detect` after bits 3 and 6 only; `match_count`=2.
- **Target reached:** pattern=101, len=3, overlap=1, target=2; in=1,0,1,0,1. Required: `detect` after bits 3 and 5; `done`=1 together with the second `detect`; `busy`=0; `match_count`=2; next cycle IDLE with `cfg_ready`=1.
- **Gaps in `in_valid`:** pattern=111; bits 1,−,−,1,−,1 with `in_valid` low at the dashes. Required: exactly one `detect`, after the third valid bit.
- **Illegal config:** after reset, `cfg_len`=0 with `cfg_valid`=1. Required: `cfg_err` pulses; a following `start` leaves `busy`=0. Then `cfg_len`=9 with PW=8 is also rejected.
- **Abort and reset:** abort after one detect with target=5. Required: IDLE, `match_count`=1, no `done`. Then drive `rst_n` low mid-run. Required: all outputs 0, `cfg_ready`=1, `start` ignored until a new config is loaded.
